// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: instruction-decode control stage with hazard detection and
// HLT drain sequencing. Decodes the fetched instruction, detects read-after-
// write hazards against the EX (and, without forwarding, MEM) writers,
// inserts bubbles, and walks RUN -> DRAIN -> HALTED after a HLT.
//
// Optional feature macro: ID_CTRL_FWD_EN
//   defined   : forwarding exists downstream, so only load-use stalls.
//   undefined : stall on any match against the EX or MEM writer.
//
// Opcode map (if_instr[INSTR_W-1 -: 4]):
//   0 ADD  1 ADDZ 2 SUB  3 AND  4 NOR  5 SLL  6 SRL  7 SRA
//   8 LW   9 SW   A LHB  B LLB  C B    D JAL  E JR   F HLT
// ALU op codes (ex_aluOp):
//   0 ADD  1 ADDZ 2 SUB  3 AND  4 NOR  5 SLL  6 SRL  7 SRA
//   8 LHB  9 LLB  F NOP.  LW/SW use ADD for address generation;
//   B, JAL, JR and HLT carry NOP.
module id_ctrl_pipe #(
    parameter int INSTR_W  = 16,
    parameter int RA_W     = 4,
    parameter int LINK_REG = 15,
    parameter int DRAIN    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               ex_flush,
    input  logic               mem_wrRegEn,
    input  logic [RA_W-1:0]    mem_wrReg,
    output logic               id_stall,
    output logic               ex_valid,
    output logic               ex_wrRegEn,
    output logic               ex_memRd,
    output logic               ex_memWr,
    output logic               ex_sawBr,
    output logic               ex_sawJ,
    output logic               ex_hlt,
    output logic               ex_rdEn1,
    output logic               ex_rdEn2,
    output logic [RA_W-1:0]    ex_rdReg1,
    output logic [RA_W-1:0]    ex_rdReg2,
    output logic [RA_W-1:0]    ex_wrReg,
    output logic [3:0]         ex_aluOp,
    output logic [3:0]         ex_shAmt,
    output logic               halted
);

    localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDZ = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8, OP_SW   = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC, OP_JAL  = 4'hD, OP_JR  = 4'hE, OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_ADDZ = 4'h1, ALU_SUB = 4'h2, ALU_AND = 4'h3;
    localparam logic [3:0] ALU_NOR = 4'h4, ALU_SLL  = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_LHB = 4'h8, ALU_LLB  = 4'h9, ALU_NOP = 4'hF;

    localparam logic [RA_W-1:0] LINK_ADDR = LINK_REG[RA_W-1:0];
    localparam logic [3:0]      DRAIN_CNT = DRAIN[3:0];

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              halted_q;
    logic              ex_valid_q, ex_wr_en_q, ex_mem_rd_q, ex_mem_wr_q;
    logic              ex_saw_br_q, ex_saw_j_q, ex_hlt_q, ex_rd_en1_q, ex_rd_en2_q;
    logic [RA_W-1:0]   ex_rd_reg1_q, ex_rd_reg2_q, ex_wr_reg_q;
    logic [3:0]        ex_alu_op_q, ex_sh_amt_q;

    // ---------------------------------------------------------------
    // Combinational decode of the instruction sitting in IF/ID
    // ---------------------------------------------------------------
    logic [3:0]        opcode;
    logic              op_hlt, op_llb, op_b, op_jal, op_jr, op_sw, op_lw, op_lhb;
    logic              dec_rd_en1, dec_rd_en2, dec_wr_en;
    logic [RA_W-1:0]   dec_rd_reg1, dec_rd_reg2, dec_wr_reg;
    logic [3:0]        dec_alu_op, dec_sh_amt;

    assign opcode = if_instr[INSTR_W-1 -: 4];
    assign op_hlt = (opcode == OP_HLT);
    assign op_llb = (opcode == OP_LLB);
    assign op_b   = (opcode == OP_B);
    assign op_jal = (opcode == OP_JAL);
    assign op_jr  = (opcode == OP_JR);
    assign op_sw  = (opcode == OP_SW);
    assign op_lw  = (opcode == OP_LW);
    assign op_lhb = (opcode == OP_LHB);

    assign dec_rd_en1  = !(op_hlt || op_llb || op_b || op_jal);
    assign dec_rd_en2  = (opcode == OP_ADD) || (opcode == OP_ADDZ) || (opcode == OP_SUB) ||
                         (opcode == OP_AND) || (opcode == OP_NOR);
    assign dec_wr_en   = !(op_hlt || op_sw || op_b || op_jr);
    // LHB and SW read the register named in the destination field
    assign dec_rd_reg1 = (op_lhb || op_sw) ? if_instr[8 +: RA_W] : if_instr[4 +: RA_W];
    assign dec_rd_reg2 = if_instr[0 +: RA_W];
    assign dec_wr_reg  = op_jal ? LINK_ADDR : if_instr[8 +: RA_W];
    assign dec_sh_amt  = if_instr[3:0];

    // ALU operation select per opcode
    always_comb begin
        dec_alu_op = ALU_NOP;
        case (opcode)
            OP_ADD:  dec_alu_op = ALU_ADD;
            OP_ADDZ: dec_alu_op = ALU_ADDZ;
            OP_SUB:  dec_alu_op = ALU_SUB;
            OP_AND:  dec_alu_op = ALU_AND;
            OP_NOR:  dec_alu_op = ALU_NOR;
            OP_SLL:  dec_alu_op = ALU_SLL;
            OP_SRL:  dec_alu_op = ALU_SRL;
            OP_SRA:  dec_alu_op = ALU_SRA;
            OP_LW:   dec_alu_op = ALU_ADD;
            OP_SW:   dec_alu_op = ALU_ADD;
            OP_LHB:  dec_alu_op = ALU_LHB;
            OP_LLB:  dec_alu_op = ALU_LLB;
            default: dec_alu_op = ALU_NOP;
        endcase
    end

    // ---------------------------------------------------------------
    // Hazard detection; register 0 is hard-wired and never matches
    // ---------------------------------------------------------------
    logic ex_hit, hazard, hz_stall;

    assign ex_hit = ex_valid_q && ex_wr_en_q && (ex_wr_reg_q != '0) &&
                    ((dec_rd_en1 && (dec_rd_reg1 == ex_wr_reg_q)) ||
                     (dec_rd_en2 && (dec_rd_reg2 == ex_wr_reg_q)));

`ifdef ID_CTRL_FWD_EN
    // Forwarding covers everything except a value still being loaded
    logic unused_mem_writer;
    assign unused_mem_writer = ^{mem_wrRegEn, mem_wrReg};
    assign hazard = ex_hit && ex_mem_rd_q;
`else
    logic mem_hit;
    assign mem_hit = mem_wrRegEn && (mem_wrReg != '0) &&
                     ((dec_rd_en1 && (dec_rd_reg1 == mem_wrReg)) ||
                      (dec_rd_en2 && (dec_rd_reg2 == mem_wrReg)));
    assign hazard = ex_hit || mem_hit;
`endif

    assign hz_stall = if_valid && hazard && (state_q == ST_RUN);

    // Flush overrides hazard and drain stalls; HALTED holds regardless
    assign id_stall = (state_q == ST_HALTED) ||
                      (!ex_flush && ((state_q == ST_DRAIN) || hz_stall));

    // ID/EX register, drain counter and RUN/DRAIN/HALTED sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_wr_en_q   <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_saw_br_q  <= 1'b0;
            ex_saw_j_q   <= 1'b0;
            ex_hlt_q     <= 1'b0;
            ex_rd_en1_q  <= 1'b0;
            ex_rd_en2_q  <= 1'b0;
            ex_rd_reg1_q <= '0;
            ex_rd_reg2_q <= '0;
            ex_wr_reg_q  <= '0;
            ex_alu_op_q  <= ALU_NOP;
            ex_sh_amt_q  <= '0;
        end else begin
            // Bubble unless an instruction is accepted below
            ex_valid_q   <= 1'b0;
            ex_wr_en_q   <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_saw_br_q  <= 1'b0;
            ex_saw_j_q   <= 1'b0;
            ex_hlt_q     <= 1'b0;
            ex_rd_en1_q  <= 1'b0;
            ex_rd_en2_q  <= 1'b0;
            ex_rd_reg1_q <= '0;
            ex_rd_reg2_q <= '0;
            ex_wr_reg_q  <= '0;
            ex_alu_op_q  <= ALU_NOP;
            ex_sh_amt_q  <= '0;
            case (state_q)
                ST_RUN: begin
                    if (if_valid && !ex_flush && !hz_stall) begin
                        ex_valid_q   <= 1'b1;
                        ex_wr_en_q   <= dec_wr_en;
                        ex_mem_rd_q  <= op_lw;
                        ex_mem_wr_q  <= op_sw;
                        ex_saw_br_q  <= op_b;
                        ex_saw_j_q   <= op_jal || op_jr;
                        ex_hlt_q     <= op_hlt;
                        ex_rd_en1_q  <= dec_rd_en1;
                        ex_rd_en2_q  <= dec_rd_en2;
                        ex_rd_reg1_q <= dec_rd_reg1;
                        ex_rd_reg2_q <= dec_rd_reg2;
                        ex_wr_reg_q  <= dec_wr_reg;
                        ex_alu_op_q  <= dec_alu_op;
                        ex_sh_amt_q  <= dec_sh_amt;
                        if (op_hlt) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= DRAIN_CNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ex_flush) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_wrRegEn = ex_wr_en_q;
    assign ex_memRd   = ex_mem_rd_q;
    assign ex_memWr   = ex_mem_wr_q;
    assign ex_sawBr   = ex_saw_br_q;
    assign ex_sawJ    = ex_saw_j_q;
    assign ex_hlt     = ex_hlt_q;
    assign ex_rdEn1   = ex_rd_en1_q;
    assign ex_rdEn2   = ex_rd_en2_q;
    assign ex_rdReg1  = ex_rd_reg1_q;
    assign ex_rdReg2  = ex_rd_reg2_q;
    assign ex_wrReg   = ex_wr_reg_q;
    assign ex_aluOp   = ex_alu_op_q;
    assign ex_shAmt   = ex_sh_amt_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Testbench for id_ctrl_pipe. Expected ID/EX contents are pushed to a
// scoreboard queue when an instruction is presented and popped after the
// clock edge. A small MEM-stage register is modelled here by delaying the
// DUT's EX writer by one cycle. Build with or without ID_CTRL_FWD_EN.
module tb_id_ctrl_pipe;

    typedef struct packed {
        logic       valid, wr_en, mem_rd, mem_wr, saw_br, saw_j, hlt, rd_en1, rd_en2;
        logic [3:0] rd1, rd2, wr, alu, sh;
    } ex_t;

    typedef struct packed {
        logic        v;
        logic [15:0] ins;
        logic        fl;
        logic        st;
        logic        hl;
    } stim_t;

    localparam logic [3:0] NOP = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic        ex_flush = 1'b0;
    logic        mem_wrRegEn = 1'b0;
    logic [3:0]  mem_wrReg = '0;
    logic        id_stall, ex_valid, ex_wrRegEn, ex_memRd, ex_memWr, ex_sawBr, ex_sawJ;
    logic        ex_hlt, ex_rdEn1, ex_rdEn2, halted;
    logic [3:0]  ex_rdReg1, ex_rdReg2, ex_wrReg, ex_aluOp, ex_shAmt;

    int  n_tests = 0;
    int  n_fail  = 0;
    ex_t sb[$];

    id_ctrl_pipe #(.INSTR_W(16), .RA_W(4), .LINK_REG(15), .DRAIN(3)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .ex_flush(ex_flush), .mem_wrRegEn(mem_wrRegEn), .mem_wrReg(mem_wrReg),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_wrRegEn(ex_wrRegEn),
        .ex_memRd(ex_memRd), .ex_memWr(ex_memWr), .ex_sawBr(ex_sawBr), .ex_sawJ(ex_sawJ),
        .ex_hlt(ex_hlt), .ex_rdEn1(ex_rdEn1), .ex_rdEn2(ex_rdEn2), .ex_rdReg1(ex_rdReg1),
        .ex_rdReg2(ex_rdReg2), .ex_wrReg(ex_wrReg), .ex_aluOp(ex_aluOp),
        .ex_shAmt(ex_shAmt), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode, written as one row per opcode
    function automatic ex_t model(input logic [15:0] ins);
        ex_t e;
        e = '0;
        e.valid = 1'b1; e.wr_en = 1'b1; e.rd_en1 = 1'b1;
        e.rd1 = ins[7:4]; e.rd2 = ins[3:0]; e.wr = ins[11:8]; e.sh = ins[3:0]; e.alu = NOP;
        case (ins[15:12])
            4'h0: begin e.alu = 4'h0; e.rd_en2 = 1'b1; end
            4'h1: begin e.alu = 4'h1; e.rd_en2 = 1'b1; end
            4'h2: begin e.alu = 4'h2; e.rd_en2 = 1'b1; end
            4'h3: begin e.alu = 4'h3; e.rd_en2 = 1'b1; end
            4'h4: begin e.alu = 4'h4; e.rd_en2 = 1'b1; end
            4'h5: e.alu = 4'h5;
            4'h6: e.alu = 4'h6;
            4'h7: e.alu = 4'h7;
            4'h8: begin e.alu = 4'h0; e.mem_rd = 1'b1; end
            4'h9: begin e.alu = 4'h0; e.mem_wr = 1'b1; e.wr_en = 1'b0; e.rd1 = ins[11:8]; end
            4'hA: begin e.alu = 4'h8; e.rd1 = ins[11:8]; end
            4'hB: begin e.alu = 4'h9; e.rd_en1 = 1'b0; end
            4'hC: begin e.saw_br = 1'b1; e.rd_en1 = 1'b0; e.wr_en = 1'b0; end
            4'hD: begin e.saw_j = 1'b1; e.rd_en1 = 1'b0; e.wr = 4'd15; end
            4'hE: begin e.saw_j = 1'b1; e.wr_en = 1'b0; end
            default: begin e.hlt = 1'b1; e.rd_en1 = 1'b0; e.wr_en = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic ex_t bubble();
        ex_t e;
        e = '0;
        e.alu = NOP;
        return e;
    endfunction

    function automatic ex_t actual();
        ex_t a;
        a = {ex_valid, ex_wrRegEn, ex_memRd, ex_memWr, ex_sawBr, ex_sawJ, ex_hlt,
             ex_rdEn1, ex_rdEn2, ex_rdReg1, ex_rdReg2, ex_wrReg, ex_aluOp, ex_shAmt};
        return a;
    endfunction

    function automatic stim_t mk(input logic v, input logic [15:0] ins, input logic fl,
                                 input logic st, input logic hl);
        stim_t s;
        s.v = v; s.ins = ins; s.fl = fl; s.st = st; s.hl = hl;
        return s;
    endfunction

    function automatic ex_t expect_of(input stim_t s);
        return (!s.v || s.fl || s.st) ? bubble() : model(s.ins);
    endfunction

    // One clock: capture the EX writer, advance, and shift it into the MEM model
    task automatic adv();
        logic       en;
        logic [3:0] r;
        en = ex_valid & ex_wrRegEn;
        r  = ex_wrReg;
        @(posedge clk);
        #1;
        mem_wrRegEn = en;
        mem_wrReg   = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; ex_flush = 1'b0;
        mem_wrRegEn = 1'b0; mem_wrReg = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (actual() !== bubble()) begin
            n_fail++; $display("FAIL reset ex: got %h want %h", actual(), bubble());
        end
        n_tests++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset halted: got %b want 0", halted); end
        n_tests++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", id_stall); end
        $display("[TB] reset ex=%h halted=%b stall=%b", actual(), halted, id_stall);
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t t[$];
        t.push_back(mk(1, 16'h8210, 0, 0, 0));   // LW  R2,(R1)
        t.push_back(mk(1, 16'h0321, 0, 1, 0));   // ADD R3,R2,R1
`ifdef ID_CTRL_FWD_EN
        t.push_back(mk(1, 16'h0321, 0, 0, 0));
`else
        t.push_back(mk(1, 16'h0321, 0, 1, 0));
        t.push_back(mk(1, 16'h0321, 0, 0, 0));
`endif
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(1, 16'h8210, 0, 0, 0));   // LW  R2,(R1)
        t.push_back(mk(1, 16'h9230, 0, 1, 0));   // SW  R2,0(R3)
`ifdef ID_CTRL_FWD_EN
        t.push_back(mk(1, 16'h9230, 0, 0, 0));
`else
        t.push_back(mk(1, 16'h9230, 0, 1, 0));
        t.push_back(mk(1, 16'h9230, 0, 0, 0));
`endif
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL load_use stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL load_use ex step%0d: got %h want %h", i, a, e); end
            $display("[TB] load_use step%0d instr=%h stall=%b ex=%h", i, t[i].ins, t[i].st, a);
        end
    endtask

    task automatic test_raw();
        stim_t t[$];
        t.push_back(mk(1, 16'h0267, 0, 0, 0));   // ADD R2,R6,R7
        t.push_back(mk(1, 16'h2425, 0, 0, 0));   // SUB R4,R2,R5
`ifndef ID_CTRL_FWD_EN
        t[1].st = 1'b1;
        t.push_back(mk(1, 16'h2425, 0, 1, 0));
        t.push_back(mk(1, 16'h2425, 0, 0, 0));
`endif
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(1, 16'h3589, 0, 0, 0));   // AND R5,R8,R9
        t.push_back(mk(1, 16'h4615, 0, 0, 0));   // NOR R6,R1,R5 (rt match)
`ifndef ID_CTRL_FWD_EN
        t[t.size()-1].st = 1'b1;
        t.push_back(mk(1, 16'h4615, 0, 1, 0));
        t.push_back(mk(1, 16'h4615, 0, 0, 0));
`endif
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(1, 16'h0267, 0, 0, 0));   // ADD R2,R6,R7
        t.push_back(mk(1, 16'h389A, 0, 0, 0));   // AND R8,R9,R10 (independent)
`ifdef ID_CTRL_FWD_EN
        t.push_back(mk(1, 16'h2425, 0, 0, 0));   // SUB: writer only in MEM
`else
        t.push_back(mk(1, 16'h2425, 0, 1, 0));
        t.push_back(mk(1, 16'h2425, 0, 0, 0));
`endif
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL raw stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL raw ex step%0d: got %h want %h", i, a, e); end
            $display("[TB] raw step%0d instr=%h stall=%b ex=%h", i, t[i].ins, t[i].st, a);
        end
    endtask

    task automatic test_r0();
        stim_t t[$];
        t.push_back(mk(1, 16'h8010, 0, 0, 0));   // LW  R0,(R1)
        t.push_back(mk(1, 16'h0301, 0, 0, 0));   // ADD R3,R0,R1
        t.push_back(mk(1, 16'h0500, 0, 0, 0));   // ADD R5,R0,R0
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL r0 stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL r0 ex step%0d: got %h want %h", i, a, e); end
            $display("[TB] r0 step%0d instr=%h stall=%b ex=%h", i, t[i].ins, t[i].st, a);
        end
    endtask

    task automatic test_decode();
        stim_t t[$];
        t.push_back(mk(1, 16'hD123, 0, 0, 0));   // JAL
        t.push_back(mk(1, 16'hC456, 0, 0, 0));   // B
        t.push_back(mk(1, 16'hE040, 0, 0, 0));   // JR  R4
        t.push_back(mk(1, 16'hA3FF, 0, 0, 0));   // LHB R3
        t.push_back(mk(1, 16'hB7AB, 0, 0, 0));   // LLB R7
        t.push_back(mk(1, 16'h5123, 0, 0, 0));   // SLL R1,R2,3
        t.push_back(mk(1, 16'h7ABC, 0, 0, 0));   // SRA R10,R11,12
        t.push_back(mk(1, 16'h1944, 0, 0, 0));   // ADDZ R9,R4,R4
        t.push_back(mk(1, 16'h6DE1, 0, 0, 0));   // SRL R13,R14,1
        t.push_back(mk(0, 16'h0321, 0, 0, 0));   // not valid -> bubble
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL decode stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL decode ex step%0d: got %h want %h", i, a, e); end
            $display("[TB] decode step%0d instr=%h ex=%h", i, t[i].ins, a);
        end
    endtask

    task automatic test_halt();
        stim_t t[$];
        do_reset();
        t.push_back(mk(1, 16'hF000, 0, 0, 0));   // HLT
        t.push_back(mk(1, 16'h0321, 0, 1, 0));
        t.push_back(mk(1, 16'h0321, 0, 1, 0));
        t.push_back(mk(1, 16'h0321, 0, 1, 0));
        t.push_back(mk(1, 16'h0321, 0, 1, 1));   // 4th edge after HLT -> halted
        t.push_back(mk(1, 16'h0321, 0, 1, 1));
        t.push_back(mk(1, 16'h0321, 1, 1, 1));   // flush ignored when halted
        t.push_back(mk(1, 16'h0267, 0, 1, 1));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL halt stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL halt ex step%0d: got %h want %h", i, a, e); end
            n_tests++;
            if (halted !== t[i].hl) begin
                n_fail++; $display("FAIL halt halted step%0d: got %b want %b", i, halted, t[i].hl);
            end
            $display("[TB] halt step%0d instr=%h stall=%b halted=%b ex=%h", i, t[i].ins, id_stall, halted, a);
        end
    endtask

    task automatic test_flush();
        stim_t t[$];
        do_reset();
        t.push_back(mk(1, 16'hF000, 0, 0, 0));   // HLT
        t.push_back(mk(1, 16'h0321, 0, 1, 0));   // first drain cycle
        t.push_back(mk(1, 16'h0321, 1, 0, 0));   // flush in second drain cycle
        t.push_back(mk(1, 16'h0267, 0, 0, 0));   // back in RUN: accepted
        for (int k = 0; k < 5; k++) t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(1, 16'h8210, 0, 0, 0));   // LW  R2,(R1)
        t.push_back(mk(1, 16'h0321, 1, 0, 0));   // hazard + flush: flush wins
        t.push_back(mk(1, 16'h3589, 0, 0, 0));   // AND R5,R8,R9
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        t.push_back(mk(0, 16'h0000, 0, 0, 0));
        foreach (t[i]) begin
            ex_t e, a;
            if_valid = t[i].v; if_instr = t[i].ins; ex_flush = t[i].fl;
            #1;
            n_tests++;
            if (id_stall !== t[i].st) begin
                n_fail++; $display("FAIL flush stall step%0d: got %b want %b", i, id_stall, t[i].st);
            end
            sb.push_back(expect_of(t[i]));
            adv();
            e = sb.pop_front(); a = actual();
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL flush ex step%0d: got %h want %h", i, a, e); end
            n_tests++;
            if (halted !== t[i].hl) begin
                n_fail++; $display("FAIL flush halted step%0d: got %b want %b", i, halted, t[i].hl);
            end
            $display("[TB] flush step%0d instr=%h fl=%b stall=%b ex=%h", i, t[i].ins, t[i].fl, t[i].st, a);
        end
        ex_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        ex_t e;
        do_reset();
        if_valid = 1'b1; if_instr = 16'hD123; ex_flush = 1'b0;
        #1;
        sb.push_back(model(16'hD123));
        adv();
        e = sb.pop_front();
        n_tests++;
        if (actual() !== e) begin n_fail++; $display("FAIL async jal ex: got %h want %h", actual(), e); end
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (actual() !== bubble()) begin
            n_fail++; $display("FAIL async clear ex: got %h want %h", actual(), bubble());
        end
        $display("[TB] async reset mid-cycle ex=%h", actual());
        do_reset();
        // Enter DRAIN, then reset before it completes
        if_valid = 1'b1; if_instr = 16'hF000;
        #1;
        adv();
        if_instr = 16'h0267;
        #1;
        n_tests++;
        if (id_stall !== 1'b1) begin n_fail++; $display("FAIL async drain stall: got %b want 1", id_stall); end
        adv();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL async drain abort stall: got %b want 0", id_stall); end
        n_tests++;
        if (actual() !== bubble()) begin
            n_fail++; $display("FAIL async drain clear ex: got %h want %h", actual(), bubble());
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ex_t x;
            if_valid = 1'b1; if_instr = 16'h0267;
            #1;
            n_tests++;
            if (id_stall !== 1'b0) begin
                n_fail++; $display("FAIL post_abort stall step%0d: got %b want 0", i, id_stall);
            end
            sb.push_back(model(16'h0267));
            adv();
            x = sb.pop_front();
            n_tests++;
            if (actual() !== x) begin
                n_fail++; $display("FAIL post_abort ex step%0d: got %h want %h", i, actual(), x);
            end
            n_tests++;
            if (halted !== 1'b0) begin
                n_fail++; $display("FAIL post_abort halted step%0d: got %b want 0", i, halted);
            end
            $display("[TB] post_abort step%0d stall=%b halted=%b ex=%h", i, id_stall, halted, actual());
        end
        if_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_raw();
        test_r0();
        test_decode();
        test_halt();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ctrl_pipe.md
ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

Interface
REQ-001 Parameters SHALL be: INSTR_W, 16, instruction width; RA_W, 4, register-address width; LINK_REG, 15, JAL destination register; DRAIN, 3, cycles to drain after HLT (1..15).
REQ-002 One clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 if_valid  input  1  fetch presents a valid instruction.
REQ-006 if_instr  input  INSTR_W  instruction; opcode in [INSTR_W-1:INSTR_W-4], encodings per defines.v.
REQ-007 ex_flush  input  1  branch/jump taken in EX; kill the instruction in ID.
REQ-008 mem_wrRegEn, mem_wrReg  input  1, RA_W  MEM-stage writer (used only without FWD_EN).
REQ-009 id_stall  output  1  hold PC and IF/ID register this cycle.
REQ-010 ex_valid, ex_wrRegEn, ex_memRd, ex_memWr, ex_sawBr, ex_sawJ, ex_hlt, ex_rdEn1, ex_rdEn2  output  1 each  registered ID/EX control.
REQ-011 ex_rdReg1, ex_rdReg2, ex_wrReg  output  RA_W each; ex_aluOp, ex_shAmt  output  4 each  registered ID/EX fields.
REQ-012 halted  output  1  pipeline drained after HLT; sticky.

Function
REQ-013 Decode SHALL be combinational from if_instr: rdEn1 low for HLT/LLB/B/JAL; rdEn2 high only for ADD/ADDZ/SUB/AND/NOR; wrRegEn low for HLT/SW/B/JR; rdReg1 = [11:8] for LHB/SW else [7:4]; rdReg2 = [3:0]; wrReg = LINK_REG for JAL else [11:8]; shAmt = [3:0]; aluOp per opcode, ALU_NOP otherwise.
REQ-014 All ex_* outputs SHALL register decode with 1-cycle latency; ex_valid = if_valid when no bubble/flush.
REQ-015 Hazard: match = (rdEn1 and rdReg1==ex_wrReg) or (rdEn2 and rdReg2==ex_wrReg) with ex_valid and ex_wrRegEn; reads/writes of register 0 never match.
REQ-016 With FWD_EN, load-use (match and ex_memRd) SHALL assert id_stall combinationally and load a bubble (ex_valid=0, all enables 0) next edge.
REQ-017 State machine SHALL have RUN, DRAIN, HALTED; reset to RUN.
REQ-018 RUN: valid HLT decoded and no flush -> register HLT, go DRAIN, load counter = DRAIN.
REQ-019 DRAIN: id_stall=1, bubbles inserted, counter decrements each cycle; at 0 -> HALTED.
REQ-020 HALTED: halted=1, id_stall=1, bubbles only, until reset.
REQ-021 ex_flush SHALL override stall and halt: next edge ex_valid=0, id_stall=0 that cycle, DRAIN -> RUN; flush in HALTED ignored.
REQ-022 Stall and flush same cycle: flush wins, no extra bubble.

Reset
REQ-023 rst_n low SHALL immediately clear every ex_* output to 0, ex_aluOp to ALU_NOP, halted 0, counter 0, state RUN, independent of clk; reset during DRAIN aborts the halt.

Configuration
REQ-024 Macro ID_CTRL_FWD_EN: defined -> stall only on load-use per REQ-016; undefined -> stall on any match against EX writer, or against mem_wrRegEn/mem_wrReg, regardless of ex_memRd.

Verification
REQ-025 LW R2,... then ADD R3,R2,R1 (FWD_EN) -> id_stall=1 one cycle, one bubble, ADD enters EX next cycle.
REQ-026 ADD R2,... then SUB R4,R2,R5: FWD_EN -> no stall; without -> two stall cycles (EX then MEM match).
REQ-027 LW R0,... then ADD R3,R0,R1 -> no stall.
REQ-028 HLT with DRAIN=3 -> ex_hlt=1 next cycle, id_stall high, halted=1 exactly 4 cycles after HLT decode.
REQ-029 ex_flush asserted second DRAIN cycle -> state RUN, halted stays 0, ex_valid=0 next edge.
REQ-030 JAL decoded -> ex_wrReg=15, ex_sawJ=1, ex_rdEn1=0; rst_n low mid-stream -> all ex_* 0 asynchronously.
